top_level: RTL and testbench
============================

TOP_LEVEL -- requirements
Module: top_level

Interface
REQ-001 Single clock domain: all state SHALL be clocked on the rising edge of PCLK; reset is synchronous and active-low (PRESETn sampled on PCLK).
REQ-002 Ports SHALL be:
 PCLK     in     1  system/APB clock
 PRESETn  in     1  synchronous active-low reset
 PSELx    in     1  APB select
 PENABLE  in     1  APB access phase
 PWRITE   in     1  1=write, 0=read
 PADDR    in     8  register select in PADDR[7:5]
 PWDATA   in     8  write data
 core_clk in     1  I2C timebase input, sampled as data in PCLK domain (not a clock)
 PRDATA   out    8  read data
 PREADY   out    1  transfer complete
 sda      inout  1  I2C data, open-drain (drive 0 or Z)
 scl      out    1  I2C clock, push-pull
REQ-003 Register map by PADDR[7:5]: 001 PRESCALE (RW), 010 SLAVE_ADDR (RW), 011 STATUS (RO), 100 TX_DATA (WO, pushes TX FIFO), 101 RX_DATA (RO, pops RX FIFO), 110 COMMAND (RW); other codes: writes ignored, reads 0.

Function
REQ-004 APB zero-wait: PREADY=1 when PSELx&PENABLE, else 0; a write commits exactly once, in the PCLK cycle where PSELx&PENABLE&PWRITE.
REQ-005 PRDATA SHALL present the selected register combinationally while PSELx&!PWRITE, else 0; an RX_DATA read pops one byte at PSELx&PENABLE.
REQ-006 SLAVE_ADDR[7:1] = 7-bit slave address; SLAVE_ADDR[0]=1 selects master-transmit (bus R/W bit 0), 0 selects master-receive (bus R/W bit 1).
REQ-007 COMMAND[7]=EN (core enable), COMMAND[4]=START; START SHALL self-clear when the transaction begins; a START written while busy or with EN=0 SHALL be ignored.
REQ-008 STATUS bits: [0] busy, [1] TX full, [2] TX empty, [3] RX full, [4] RX empty, [5] NACK received (sticky, cleared by next accepted START), [7:6] 0.
REQ-009 TX and RX FIFOs SHALL each be 8 deep x 8 bits; push when full and pop when empty SHALL be ignored (no pointer change); simultaneous push/pop SHALL both occur.
REQ-010 Timebase: a tick SHALL be one PCLK-cycle pulse on each rising edge of core_clk (two-flop sync plus edge detect); SCL half-period SHALL be PRESCALE ticks (PRESCALE=0 treated as 1).
REQ-011 FSM states: IDLE, START, ADDR, ADDR_ACK, TX_BYTE, TX_ACK, RX_BYTE, RX_ACK, STOP; return to IDLE after STOP.
REQ-012 IDLE: scl=1, sda released; accepted START -> START state: sda low while scl high for one half-period, then scl low.
REQ-013 Bits MSB first; sda changes only while scl low; each bit = one low half-period + one high half-period.
REQ-014 ADDR sends {SLAVE_ADDR[7:1], R/W}; in ACK slots master releases sda and samples it at the scl rising edge; 0 = ACK.
REQ-015 Transmit: after ACK, pop TX FIFO and send byte; continue while TX FIFO non-empty at each ACK; when empty, go to STOP; bytes pushed during a transfer SHALL be sent in the same transaction.
REQ-016 Receive: shift sda on scl rise into RX FIFO; master drives ACK (0) except on the byte that fills RX FIFO, where it releases (NACK) then STOPs.
REQ-017 Any NACK on address or data SHALL set STATUS[5] and go directly to STOP; remaining TX bytes stay in FIFO.
REQ-018 STOP: sda low with scl low, scl high one half-period, then sda released one half-period; busy clears on entry to IDLE.
REQ-019 Clearing EN mid-transaction SHALL finish the current byte, then STOP.

Reset
REQ-020 While PRESETn=0 on a PCLK edge: all registers 0, FIFOs empty, FSM IDLE, scl=1, sda released, PREADY=0, PRDATA=0, STATUS=0x14.
REQ-021 Reset asserted mid-transaction SHALL abort immediately to the reset state with no STOP generated.

Verification (bench uses a pull-up on sda, PCLK 10 ns, core_clk 40 ns)
REQ-022 Reset 100 ns, read STATUS -> 0x14; scl=1, sda high.
REQ-023 PRESCALE=4, SLAVE_ADDR=0x21, TX_DATA=0x01, COMMAND=0x90, then TX_DATA 0x02..0x08; slave ACKs 9 slots -> START, byte 0x20, bytes 0x01..0x08, STOP; scl period 320 ns; STATUS ends 0x14.
REQ-024 Same as REQ-023 but slave NACKs address -> STOP after address ACK slot, STATUS[5]=1, TX FIFO holds remaining bytes.
REQ-025 Push 9 bytes to TX_DATA with EN=0 -> STATUS[1]=1, exactly 8 bytes later transmitted.
REQ-026 SLAVE_ADDR=0x20, COMMAND=0x90, slave ACKs and returns 0xA5 per byte -> 8 bytes received, last NACKed, STATUS[3]=1, RX_DATA reads 0xA5 eight times then STATUS[4]=1.
REQ-027 Second COMMAND=0x90 while busy -> no extra transaction after STOP.

Source files
------------

// File: rtl/top_level.sv
// APB-programmed I2C master with 8-deep TX/RX FIFOs.
// core_clk is a sampled timebase; everything runs on PCLK.
module i2c_fifo (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push,
   input  logic       pop,
   input  logic [7:0] wdata,
   output logic [7:0] rdata,
   output logic       full,
   output logic       empty
);
   logic [7:0] mem [8];
   logic [2:0] wptr;
   logic [2:0] rptr;
   logic [3:0] count;
   logic       do_push;
   logic       do_pop;

   assign full    = count == 4'd8;
   assign empty   = count == 4'd0;
   assign do_pop  = pop & ~empty;
   // a pop in the same cycle frees the slot a full push needs
   assign do_push = push & (~full | do_pop);
   assign rdata   = mem[rptr];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) wptr <= wptr + 3'd1;
         if (do_pop) rptr <= rptr + 3'd1;
         count <= count + {3'b0, do_push} - {3'b0, do_pop};
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr] <= wdata;
   end
endmodule

module top_level (
   input  logic       PCLK,
   input  logic       PRESETn,
   input  logic       PSELx,
   input  logic       PENABLE,
   input  logic       PWRITE,
   input  logic [7:0] PADDR,
   input  logic [7:0] PWDATA,
   input  logic       core_clk,
   output logic [7:0] PRDATA,
   output logic       PREADY,
   inout  wire        sda,
   output logic       scl
);
   typedef enum logic [3:0] {
      S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_TX_BYTE,
      S_TX_ACK, S_RX_BYTE, S_RX_ACK, S_STOP
   } state_t;

   localparam logic [2:0] R_PRESCALE = 3'b001;
   localparam logic [2:0] R_SLAVE    = 3'b010;
   localparam logic [2:0] R_STATUS   = 3'b011;
   localparam logic [2:0] R_TX       = 3'b100;
   localparam logic [2:0] R_RX       = 3'b101;
   localparam logic [2:0] R_COMMAND  = 3'b110;

   state_t     state;
   state_t     state_nxt;
   logic [1:0] phase;
   logic [1:0] phase_nxt;
   logic [2:0] bit_cnt;
   logic [7:0] shreg;
   logic [7:0] rx_sh;
   logic       ack_q;
   logic       nack;
   logic       rd_q;
   logic [7:0] prescale;
   logic [7:0] slave_addr;
   logic [7:0] cmd;
   logic [2:0] sync;
   logic [7:0] hcnt;
   logic [7:0] presc_eff;
   logic       tick;
   logic       half;
   logic       busy;
   logic       go;
   logic       shift;
   logic       sample;
   logic       load_addr;
   logic       tx_pop;
   logic       rx_push;
   logic       set_nack;
   logic       sda_low;
   logic       sda_in;
   logic [2:0] sel;
   logic       acc;
   logic       wr;
   logic       rx_pop;
   logic       tx_push;
   logic [7:0] tx_rdata;
   logic [7:0] rx_rdata;
   logic       tx_full;
   logic       tx_empty;
   logic       rx_full;
   logic       rx_empty;
   logic       last_bit;
   logic       unused_paddr;

   assign unused_paddr = ^PADDR[4:0];
   assign sel     = PADDR[7:5];
   assign acc     = PSELx & PENABLE;
   assign wr      = acc & PWRITE;
   assign tx_push = wr & (sel == R_TX);
   assign rx_pop  = acc & ~PWRITE & (sel == R_RX);
   assign PREADY  = acc & PRESETn;
   assign busy    = state != S_IDLE;
   assign go      = (state == S_IDLE) & cmd[4] & cmd[7];
   assign sda     = sda_low ? 1'b0 : 1'bz;
   assign sda_in  = sda;

   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         prescale   <= '0;
         slave_addr <= '0;
         cmd        <= '0;
      end else begin
         if (wr && sel == R_PRESCALE) prescale <= PWDATA;
         if (wr && sel == R_SLAVE) slave_addr <= PWDATA;
         if (wr && sel == R_COMMAND)
            cmd <= {PWDATA[7:5], PWDATA[4] & PWDATA[7] & ~busy,
                    PWDATA[3:0]};
         if (go) cmd[4] <= 1'b0;
      end
   end

   always_comb begin
      PRDATA = '0;
      if (PRESETn && PSELx && !PWRITE) begin
         case (sel)
            R_PRESCALE: PRDATA = prescale;
            R_SLAVE:    PRDATA = slave_addr;
            R_STATUS:   PRDATA = {2'b00, nack, rx_empty, rx_full,
                                  tx_empty, tx_full, busy};
            R_RX:       PRDATA = rx_rdata;
            R_COMMAND:  PRDATA = cmd;
            default:    PRDATA = '0;
         endcase
      end
   end

   i2c_fifo u_tx (
      .clk   (PCLK),
      .rst_n (PRESETn),
      .push  (tx_push),
      .pop   (tx_pop),
      .wdata (PWDATA),
      .rdata (tx_rdata),
      .full  (tx_full),
      .empty (tx_empty)
   );

   i2c_fifo u_rx (
      .clk   (PCLK),
      .rst_n (PRESETn),
      .push  (rx_push),
      .pop   (rx_pop),
      .wdata (rx_sh),
      .rdata (rx_rdata),
      .full  (rx_full),
      .empty (rx_empty)
   );

   // two-flop sync of core_clk, third flop for rising-edge detect
   assign tick      = sync[1] & ~sync[2];
   assign presc_eff = (prescale == 8'd0) ? 8'd1 : prescale;
   assign half      = busy & tick & (hcnt == presc_eff - 8'd1);

   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         sync <= '0;
         hcnt <= '0;
      end else begin
         sync <= {sync[1:0], core_clk};
         if (!busy || half) hcnt <= '0;
         else if (tick) hcnt <= hcnt + 8'd1;
      end
   end

   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         state <= S_IDLE;
         phase <= '0;
      end else begin
         state <= state_nxt;
         phase <= phase_nxt;
      end
   end

   assign last_bit = bit_cnt == 3'd0;

   always_comb begin
      state_nxt = state;
      phase_nxt = phase;
      shift     = 1'b0;
      sample    = 1'b0;
      load_addr = 1'b0;
      tx_pop    = 1'b0;
      rx_push   = 1'b0;
      set_nack  = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (go) begin
               state_nxt = S_START;
               phase_nxt = 2'd0;
            end
         end
         S_START: begin
            if (half) begin
               state_nxt = S_ADDR;
               phase_nxt = 2'd0;
               load_addr = 1'b1;
            end
         end
         S_ADDR, S_TX_BYTE: begin
            if (half) begin
               if (phase == 2'd0) begin
                  phase_nxt = 2'd1;
               end else if (last_bit) begin
                  state_nxt = (state == S_ADDR) ? S_ADDR_ACK : S_TX_ACK;
                  phase_nxt = 2'd0;
               end else begin
                  phase_nxt = 2'd0;
                  shift     = 1'b1;
               end
            end
         end
         S_ADDR_ACK, S_TX_ACK: begin
            if (half) begin
               if (phase == 2'd0) begin
                  phase_nxt = 2'd1;
                  sample    = 1'b1;
               end else begin
                  phase_nxt = 2'd0;
                  if (ack_q) begin
                     set_nack  = 1'b1;
                     state_nxt = S_STOP;
                  end else if (state == S_ADDR_ACK && rd_q) begin
                     state_nxt = cmd[7] ? S_RX_BYTE : S_STOP;
                  end else if (!cmd[7] || tx_empty) begin
                     state_nxt = S_STOP;
                  end else begin
                     state_nxt = S_TX_BYTE;
                     tx_pop    = 1'b1;
                  end
               end
            end
         end
         S_RX_BYTE: begin
            if (half) begin
               if (phase == 2'd0) begin
                  phase_nxt = 2'd1;
                  sample    = 1'b1;
               end else if (last_bit) begin
                  state_nxt = S_RX_ACK;
                  phase_nxt = 2'd0;
                  rx_push   = 1'b1;
               end else begin
                  phase_nxt = 2'd0;
                  shift     = 1'b1;
               end
            end
         end
         S_RX_ACK: begin
            if (half) begin
               if (phase == 2'd0) begin
                  phase_nxt = 2'd1;
               end else begin
                  phase_nxt = 2'd0;
                  state_nxt = (rx_full || !cmd[7]) ? S_STOP : S_RX_BYTE;
               end
            end
         end
         S_STOP: begin
            if (half) begin
               if (phase == 2'd2) begin
                  state_nxt = S_IDLE;
                  phase_nxt = 2'd0;
               end else begin
                  phase_nxt = phase + 2'd1;
               end
            end
         end
         default: begin
            state_nxt = S_IDLE;
            phase_nxt = 2'd0;
         end
      endcase
   end

   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         bit_cnt <= '0;
         shreg   <= '0;
         rx_sh   <= '0;
         ack_q   <= 1'b0;
         nack    <= 1'b0;
         rd_q    <= 1'b0;
      end else begin
         if (state_nxt != state) bit_cnt <= 3'd7;
         else if (shift) bit_cnt <= bit_cnt - 3'd1;
         if (go) begin
            nack <= 1'b0;
            rd_q <= ~slave_addr[0];
         end else if (set_nack) begin
            nack <= 1'b1;
         end
         if (load_addr) shreg <= {slave_addr[7:1], rd_q};
         else if (tx_pop) shreg <= tx_rdata;
         else if (shift) shreg <= {shreg[6:0], 1'b0};
         if (sample) begin
            ack_q <= sda_in;
            rx_sh <= {rx_sh[6:0], sda_in};
         end
      end
   end

   always_comb begin
      scl     = 1'b1;
      sda_low = 1'b0;
      unique case (state)
         S_IDLE: begin
            scl     = 1'b1;
            sda_low = 1'b0;
         end
         S_START: begin
            scl     = 1'b1;
            sda_low = 1'b1;
         end
         S_ADDR, S_TX_BYTE: begin
            scl     = phase[0];
            sda_low = ~shreg[7];
         end
         S_ADDR_ACK, S_TX_ACK, S_RX_BYTE: begin
            scl     = phase[0];
            sda_low = 1'b0;
         end
         // the byte that fills the RX FIFO is NACKed
         S_RX_ACK: begin
            scl     = phase[0];
            sda_low = ~rx_full;
         end
         S_STOP: begin
            scl     = phase != 2'd0;
            sda_low = phase != 2'd2;
         end
         default: begin
            scl     = 1'b1;
            sda_low = 1'b0;
         end
      endcase
   end
endmodule

// File: tb/tb_top_level.sv
// Directed bench for top_level: APB master plus behavioural I2C slave.
// Slave logs bytes, ACKs as told and serves rd_byte in read mode.
module tb_top_level;
   logic       PCLK     = 1'b0;
   logic       core_clk = 1'b0;
   logic       PRESETn  = 1'b0;
   logic       PSELx    = 1'b0;
   logic       PENABLE  = 1'b0;
   logic       PWRITE   = 1'b0;
   logic [7:0] PADDR    = '0;
   logic [7:0] PWDATA   = '0;
   logic [7:0] PRDATA;
   logic       PREADY;
   logic       scl;
   wire        sda;

   int checks = 0;
   int errors = 0;

   logic       slv_low  = 1'b0;
   logic       ack_addr = 1'b1;
   logic       ack_data = 1'b1;
   logic [7:0] rd_byte  = 8'hA5;
   logic       rdy_seen;
   int         start_cnt = 0;
   int         stop_cnt  = 0;
   int         bitn = 0;
   int         bidx = 0;
   logic       in_x = 1'b0;
   logic       pscl = 1'b1;
   logic       psda = 1'b1;
   logic       rd_mode = 1'b0;
   logic       ackv = 1'b1;
   logic [7:0] sh = '0;
   logic [7:0] bytes_q[$];
   logic       macks[$];
   time        rise_t[$];

   assign sda = slv_low ? 1'b0 : 1'bz;
   pullup (sda);

   always #5 PCLK = ~PCLK;
   always #20 core_clk = ~core_clk;

   top_level dut (
      .PCLK     (PCLK),
      .PRESETn  (PRESETn),
      .PSELx    (PSELx),
      .PENABLE  (PENABLE),
      .PWRITE   (PWRITE),
      .PADDR    (PADDR),
      .PWDATA   (PWDATA),
      .core_clk (core_clk),
      .PRDATA   (PRDATA),
      .PREADY   (PREADY),
      .sda      (sda),
      .scl      (scl)
   );

   always @(negedge PCLK) begin
      logic cs;
      logic cd;
      cs = scl;
      cd = (sda !== 1'b0);
      if (!PRESETn) begin
         in_x    = 1'b0;
         slv_low = 1'b0;
      end else if (pscl && cs && psda && !cd) begin
         start_cnt++;
         in_x    = 1'b1;
         bitn    = 0;
         bidx    = 0;
         sh      = '0;
         slv_low = 1'b0;
      end else if (pscl && cs && !psda && cd) begin
         stop_cnt++;
         in_x    = 1'b0;
         slv_low = 1'b0;
      end else if (in_x && !pscl && cs) begin
         if (bidx == 0) rise_t.push_back($time);
         if (bitn < 8) begin
            sh = {sh[6:0], cd};
         end else begin
            ackv = cd;
            if (bidx > 0 && rd_mode) macks.push_back(cd);
         end
         bitn++;
      end else if (in_x && pscl && !cs) begin
         if (bitn == 8) begin
            if (bidx == 0) begin
               bytes_q.push_back(sh);
               rd_mode = sh[0];
               slv_low = ack_addr;
            end else if (!rd_mode) begin
               bytes_q.push_back(sh);
               slv_low = ack_data;
            end else begin
               slv_low = 1'b0;
            end
         end else if (bitn == 9) begin
            bitn    = 0;
            bidx++;
            slv_low = 1'b0;
            if (rd_mode && !ackv) slv_low = ~rd_byte[7];
         end else if (rd_mode && bidx > 0 && bitn >= 1 && bitn <= 7) begin
            slv_low = ~rd_byte[7-bitn];
         end
      end
      pscl = cs;
      psda = cd;
   end

   task automatic apb_write(input logic [2:0] r, input logic [7:0] d);
      @(negedge PCLK);
      PSELx   = 1'b1;
      PENABLE = 1'b0;
      PWRITE  = 1'b1;
      PADDR   = {r, 5'd0};
      PWDATA  = d;
      @(negedge PCLK);
      PENABLE = 1'b1;
      @(negedge PCLK);
      PSELx   = 1'b0;
      PENABLE = 1'b0;
      PWRITE  = 1'b0;
   endtask

   task automatic apb_read(input logic [2:0] r, output logic [7:0] d);
      @(negedge PCLK);
      PSELx   = 1'b1;
      PENABLE = 1'b0;
      PWRITE  = 1'b0;
      PADDR   = {r, 5'd0};
      @(negedge PCLK);
      PENABLE = 1'b1;
      #1;
      d        = PRDATA;
      rdy_seen = PREADY;
      @(negedge PCLK);
      PSELx   = 1'b0;
      PENABLE = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge PCLK);
      PRESETn = 1'b0;
      repeat (10) @(negedge PCLK);
      start_cnt = 0;
      stop_cnt  = 0;
      bytes_q.delete();
      macks.delete();
      rise_t.delete();
      PRESETn = 1'b1;
      @(negedge PCLK);
   endtask

   task automatic wait_stop(input int n, input string name);
      int k = 0;
      while (stop_cnt < n && k < 6000) begin
         @(negedge PCLK);
         k++;
      end
      checks++;
      if (stop_cnt < n) begin
         errors++;
         $display("FAIL %s_stop: got %0d stops, expected %0d", name, stop_cnt, n);
      end
      repeat (40) @(negedge PCLK);
   endtask

   task automatic test_reset();
      logic [7:0] d;
      do_reset();
      checks++;
      if (scl !== 1'b1) begin
         errors++;
         $display("FAIL reset_scl: got %b, expected 1", scl);
      end
      checks++;
      if (sda !== 1'b1) begin
         errors++;
         $display("FAIL reset_sda: got %b, expected 1", sda);
      end
      checks++;
      if (PREADY !== 1'b0 || PRDATA !== 8'h00) begin
         errors++;
         $display("FAIL reset_idle_bus: got %b/%h, expected 0/00", PREADY, PRDATA);
      end
      apb_read(3'b011, d);
      checks++;
      if (d !== 8'h14) begin
         errors++;
         $display("FAIL reset_status: got %h, expected 14", d);
      end
      checks++;
      if (rdy_seen !== 1'b1) begin
         errors++;
         $display("FAIL pready_access: got %b, expected 1", rdy_seen);
      end
      apb_write(3'b111, 8'hFF);
      apb_write(3'b011, 8'hFF);
      apb_read(3'b111, d);
      checks++;
      if (d !== 8'h00) begin
         errors++;
         $display("FAIL unmapped_read: got %h, expected 00", d);
      end
      apb_read(3'b011, d);
      checks++;
      if (d !== 8'h14) begin
         errors++;
         $display("FAIL status_ro: got %h, expected 14", d);
      end
   endtask

   task automatic test_tx();
      logic [7:0] d;
      do_reset();
      ack_addr = 1'b1;
      ack_data = 1'b1;
      apb_write(3'b001, 8'h04);
      apb_write(3'b010, 8'h21);
      apb_write(3'b100, 8'h01);
      apb_write(3'b110, 8'h90);
      apb_read(3'b011, d);
      checks++;
      if (d[0] !== 1'b1) begin
         errors++;
         $display("FAIL tx_busy: got %h, expected busy bit set", d);
      end
      for (int i = 2; i <= 8; i++) apb_write(3'b100, 8'(i));
      wait_stop(1, "tx");
      checks++;
      if (start_cnt != 1 || bytes_q.size() != 9) begin
         errors++;
         $display("FAIL tx_count: got %0d starts %0d bytes, expected 1 and 9",
                  start_cnt, bytes_q.size());
      end
      checks++;
      if (bytes_q.size() < 1 || bytes_q[0] !== 8'h20) begin
         errors++;
         $display("FAIL tx_addr_byte: expected 20");
      end
      for (int i = 1; i <= 8; i++) begin
         checks++;
         if (bytes_q.size() <= i || bytes_q[i] !== 8'(i)) begin
            errors++;
            $display("FAIL tx_data_%0d: expected %h", i, 8'(i));
         end
      end
      checks++;
      if (rise_t.size() < 2 || rise_t[1] - rise_t[0] != 320) begin
         errors++;
         $display("FAIL scl_period: expected 320");
      end
      apb_read(3'b011, d);
      checks++;
      if (d !== 8'h14) begin
         errors++;
         $display("FAIL tx_status_end: got %h, expected 14", d);
      end
      apb_read(3'b110, d);
      checks++;
      if (d !== 8'h80) begin
         errors++;
         $display("FAIL start_selfclear: got %h, expected 80", d);
      end
   endtask

   task automatic test_nack();
      logic [7:0] d;
      do_reset();
      ack_addr = 1'b0;
      apb_write(3'b001, 8'h04);
      apb_write(3'b010, 8'h21);
      apb_write(3'b100, 8'h01);
      apb_write(3'b110, 8'h90);
      for (int i = 2; i <= 8; i++) apb_write(3'b100, 8'(i));
      wait_stop(1, "nack");
      ack_addr = 1'b1;
      checks++;
      if (bytes_q.size() != 1) begin
         errors++;
         $display("FAIL nack_bytes: got %0d bytes, expected 1", bytes_q.size());
      end
      apb_read(3'b011, d);
      checks++;
      if (d !== 8'h32) begin
         errors++;
         $display("FAIL nack_status: got %h, expected 32", d);
      end
   endtask

   task automatic test_fifo_full();
      logic [7:0] d;
      do_reset();
      apb_write(3'b001, 8'h04);
      apb_write(3'b010, 8'h21);
      for (int i = 0; i < 9; i++) apb_write(3'b100, 8'(8'h11 + i));
      apb_read(3'b011, d);
      checks++;
      if (d !== 8'h12) begin
         errors++;
         $display("FAIL fifo_full_status: got %h, expected 12", d);
      end
      apb_write(3'b110, 8'h10);
      repeat (200) @(negedge PCLK);
      checks++;
      if (start_cnt != 0) begin
         errors++;
         $display("FAIL start_en0: got %0d starts, expected 0", start_cnt);
      end
      apb_write(3'b110, 8'h90);
      wait_stop(1, "fifo");
      checks++;
      if (bytes_q.size() != 9) begin
         errors++;
         $display("FAIL fifo_bytes: got %0d bytes, expected 9", bytes_q.size());
      end
      for (int i = 1; i <= 8; i++) begin
         checks++;
         if (bytes_q.size() <= i || bytes_q[i] !== 8'(8'h10 + i)) begin
            errors++;
            $display("FAIL fifo_data_%0d: expected %h", i, 8'(8'h10 + i));
         end
      end
   endtask

   task automatic test_rx();
      logic [7:0] d;
      int zeros;
      do_reset();
      apb_write(3'b001, 8'h04);
      apb_write(3'b010, 8'h20);
      apb_write(3'b110, 8'h90);
      wait_stop(1, "rx");
      checks++;
      if (bytes_q.size() < 1 || bytes_q[0] !== 8'h21) begin
         errors++;
         $display("FAIL rx_addr_byte: expected 21");
      end
      zeros = 0;
      for (int i = 0; i < 7 && i < macks.size(); i++)
         if (macks[i] === 1'b0) zeros++;
      checks++;
      if (macks.size() != 8 || zeros != 7 || macks[7] !== 1'b1) begin
         errors++;
         $display("FAIL rx_master_ack: got %0d slots %0d acks, expected 8 and 7 then nack",
                  macks.size(), zeros);
      end
      apb_read(3'b011, d);
      checks++;
      if (d !== 8'h0C) begin
         errors++;
         $display("FAIL rx_status_full: got %h, expected 0c", d);
      end
      for (int i = 0; i < 8; i++) begin
         apb_read(3'b101, d);
         checks++;
         if (d !== 8'hA5) begin
            errors++;
            $display("FAIL rx_data_%0d: got %h, expected a5", i, d);
         end
      end
      apb_read(3'b011, d);
      checks++;
      if (d !== 8'h14) begin
         errors++;
         $display("FAIL rx_status_empty: got %h, expected 14", d);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] d;
      do_reset();
      apb_write(3'b001, 8'h04);
      apb_write(3'b010, 8'h21);
      apb_write(3'b100, 8'h55);
      apb_write(3'b110, 8'h90);
      repeat (50) @(negedge PCLK);
      apb_write(3'b110, 8'h90);
      wait_stop(1, "b2b");
      repeat (1500) @(negedge PCLK);
      checks++;
      if (start_cnt != 1 || bytes_q.size() != 2) begin
         errors++;
         $display("FAIL b2b_single: got %0d starts %0d bytes, expected 1 and 2",
                  start_cnt, bytes_q.size());
      end
      apb_read(3'b011, d);
      checks++;
      if (d !== 8'h14) begin
         errors++;
         $display("FAIL b2b_status: got %h, expected 14", d);
      end
   endtask

   task automatic test_reset_abort();
      logic [7:0] d;
      do_reset();
      apb_write(3'b001, 8'h04);
      apb_write(3'b010, 8'h21);
      for (int i = 0; i < 3; i++) apb_write(3'b100, 8'hC3);
      apb_write(3'b110, 8'h90);
      repeat (600) @(negedge PCLK);
      apb_read(3'b011, d);
      checks++;
      if (d[0] !== 1'b1) begin
         errors++;
         $display("FAIL abort_busy: got %h, expected busy bit set", d);
      end
      @(negedge PCLK);
      PRESETn = 1'b0;
      @(posedge PCLK);
      #1;
      checks++;
      if (scl !== 1'b1) begin
         errors++;
         $display("FAIL abort_scl: got %b, expected 1", scl);
      end
      repeat (5) @(negedge PCLK);
      PRESETn = 1'b1;
      repeat (500) @(negedge PCLK);
      checks++;
      if (sda !== 1'b1 || scl !== 1'b1 || start_cnt != 1) begin
         errors++;
         $display("FAIL abort_idle: got sda %b scl %b starts %0d, expected 1 1 1",
                  sda, scl, start_cnt);
      end
      apb_read(3'b011, d);
      checks++;
      if (d !== 8'h14) begin
         errors++;
         $display("FAIL abort_status: got %h, expected 14", d);
      end
   endtask

   initial begin
      test_reset();
      test_tx();
      test_nack();
      test_fifo_full();
      test_rx();
      test_back_to_back();
      test_reset_abort();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached, expected completion");
      $fatal(1);
   end
endmodule
